// File: rtl/square16.sv
// square16: iterative shift-add squarer.
// Produces y = x*x after a fixed WIDTH-cycle iteration. The result is held
// behind rdy until the next start or reset.
module square16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  output logic                 busy,
  output logic                 rdy,
  output logic [2*WIDTH-1:0]   y
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [RW-1:0]   mcand, mcand_next;
  logic [WIDTH-1:0] mplier, mplier_next;
  logic [RW-1:0]   acc, acc_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            busy_next, rdy_next;
  logic [RW-1:0]   y_next;
  logic [RW-1:0]   addend;
  logic [RW-1:0]   sum;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      rdy    <= 1'b0;
      y      <= '0;
    end else begin
      state  <= state_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      acc    <= acc_next;
      cnt    <= cnt_next;
      busy   <= busy_next;
      rdy    <= rdy_next;
      y      <= y_next;
    end
  end

  // Next-state and datapath update; one partial product is added per RUN cycle
  always_comb begin
    state_next  = state;
    mcand_next  = mcand;
    mplier_next = mplier;
    acc_next    = acc;
    cnt_next    = cnt;
    busy_next   = busy;
    rdy_next    = rdy;
    y_next      = y;
    addend      = mplier[0] ? mcand : '0;
    sum         = acc + addend;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next  = RUN;
          mcand_next  = RW'(x);
          mplier_next = x;
          acc_next    = '0;
          cnt_next    = '0;
          busy_next   = 1'b1;
          rdy_next    = 1'b0;
        end
      end
      RUN: begin
        // start is deliberately ignored here; the latched operand wins
        acc_next    = sum;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        cnt_next    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_next = DONE;
          y_next     = sum;
          rdy_next   = 1'b1;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        rdy_next   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_square16.sv
// Testbench for square16: directed sequence plus random operands checked
// against plain-arithmetic squares and an integer square root model.
module tb_square16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] x;
  logic        busy;
  logic        rdy;
  logic [31:0] y;

  int errors = 0;
  int checks = 0;

  square16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .busy  (busy),
    .rdy   (rdy),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference square: plain unsigned multiplication
  function automatic logic [31:0] ref_sq(input logic [15:0] v);
    logic [31:0] w;
    w = 32'(v);
    return w * w;
  endfunction

  // Reference integer square root (floor), stands in for sqrt32
  function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
    logic [63:0] r, t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= 64'(v)) r = t;
    end
    return 16'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a square of xv, optionally pulse a stray start at RUN cycle pulse_at,
  // then check latency, result and flag exclusivity.
  task automatic do_square(input logic [15:0] xv, input int pulse_at, input string tag,
                           output logic [31:0] got);
    int cyc;
    logic [31:0] expv;
    logic both;
    expv = ref_sq(xv);
    start = 1'b1;
    x = xv;
    step();
    start = 1'b0;
    x = 16'($urandom);
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_rdy_after_start"}, 32'(rdy), 32'd0);
    cyc = 0;
    both = 1'b0;
    while (!rdy && cyc < 40) begin
      if (cyc == pulse_at) begin
        start = 1'b1;
        x = 16'hFFFF;
      end else begin
        start = 1'b0;
        x = 16'($urandom);
      end
      step();
      cyc++;
      if (busy && rdy) both = 1'b1;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'd16);
    check({tag, "_y"}, y, expv);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_busy_rdy_excl"}, 32'(both), 32'd0);
    got = y;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] old_y;
    logic [15:0] rx;
    logic [15:0] rt_vals [5];

    reset = 1'b0;
    start = 1'b0;
    x = '0;
    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_y", y, 32'd0);
    reset = 1'b1;
    step();

    // Directed operands
    do_square(16'h0000, -1, "x0", got);
    do_square(16'hFFFF, -1, "xffff", got);
    check("xffff_const", got, 32'hFFFE0001);
    do_square(16'hB505, -1, "xb505", got);
    check("xb505_const", got, 32'h80001219);
    do_square(16'd1234, -1, "x1234", got);
    check("x1234_const", got, 32'h00173C44);

    // Hold in DONE for a few cycles
    step();
    step();
    check("done_hold_rdy", 32'(rdy), 32'd1);
    check("done_hold_y", y, 32'h00173C44);

    // Stray start during RUN is ignored
    do_square(16'd3, 5, "ignore_start", got);
    check("ignore_start_const", got, 32'h00000009);

    // Restart from DONE: rdy drops, y keeps old value until completion
    old_y = y;
    start = 1'b1;
    x = 16'd7;
    step();
    start = 1'b0;
    check("restart_rdy_low", 32'(rdy), 32'd0);
    check("restart_y_held", y, old_y);
    for (int i = 0; i < 10; i++) step();
    check("restart_y_held_mid", y, old_y);
    for (int i = 0; i < 6; i++) step();
    check("restart_rdy", 32'(rdy), 32'd1);
    check("restart_y", y, 32'd49);

    // Reset during RUN aborts and clears outputs
    start = 1'b1;
    x = 16'h1234;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    step();
    check("abort_rdy", 32'(rdy), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_y", y, 32'd0);
    reset = 1'b1;
    step();
    do_square(16'd2, -1, "after_abort", got);
    check("after_abort_const", got, 32'd4);

    // Reset overrides start
    reset = 1'b0;
    start = 1'b1;
    x = 16'h00FF;
    step();
    step();
    step();
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_rdy", 32'(rdy), 32'd0);
    reset = 1'b1;
    start = 1'b0;
    step();
    check("rst_release_idle_busy", 32'(busy), 32'd0);

    // Round trip through the reference square root
    rt_vals[0] = 16'd0;
    rt_vals[1] = 16'd1;
    rt_vals[2] = 16'd255;
    rt_vals[3] = 16'd46341;
    rt_vals[4] = 16'd65535;
    for (int i = 0; i < 5; i++) begin
      do_square(rt_vals[i], -1, "roundtrip", got);
      check("roundtrip_sqrt", 32'(ref_isqrt(got)), 32'(rt_vals[i]));
    end

    // Random operands, some back-to-back from the first DONE cycle
    for (int i = 0; i < 100; i++) begin
      rx = 16'($urandom);
      do_square(rx, (i % 7 == 3) ? int'($urandom_range(0, 15)) : -1, "rand", got);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
